// File: rtl/mem_wb_stage_pkg.sv
// Shared types and default widths for the memory / writeback stage.
package mem_wb_stage_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_RA_W   = 4;

  typedef struct packed {
    logic regWrite;
    logic PCSrc;
    logic memToReg;
    logic memWrite;
  } ctrl_t;

  typedef enum logic {READY = 1'b0, WAIT = 1'b1} mstate_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Tracks an outstanding memory access: completion on ack, abort after TIMEOUT wait cycles.
module mem_wait_timer
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic acc,
  input  logic mem_ack,
  output logic done,
  output logic aborted
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  mstate_t       r_state;
  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_state == WAIT) && (r_cnt == CMAX);
  // An ack arriving together with expiry completes the access normally.
  assign done      = !acc || mem_ack || w_expired;
  assign aborted   = acc && w_expired && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= READY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        READY: if (acc && !mem_ack) begin
          r_state <= WAIT;
          r_cnt   <= CW'(1);
        end
        WAIT: if (mem_ack || w_expired) begin
          r_state <= READY;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + CW'(1);
        end
        default: begin
          r_state <= READY;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage with EX->M and M->W pipeline registers; stalls upstream while an access is pending.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RA_W    = DEF_RA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteE,
  input  logic              PCSrcE,
  input  logic              memToRegE,
  input  logic              memWriteE,
  input  logic [RA_W-1:0]   WA3E,
  input  logic [DATA_W-1:0] aluResE,
  input  logic [DATA_W-1:0] writeDataE,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  input  logic              mem_err_clr,
  output logic              mem_err,
  output logic [DATA_W-1:0] resultW,
  output logic [RA_W-1:0]   WA3W,
  output logic              regWriteW,
  output logic              PCSrcW
);
  ctrl_t             r_ctrlM;
  logic [RA_W-1:0]   r_WA3M;
  logic [DATA_W-1:0] r_aluResM;
  logic [DATA_W-1:0] r_writeDataM;

  logic [DATA_W-1:0] r_resultW;
  logic [RA_W-1:0]   r_WA3W;
  logic              r_regWriteW;
  logic              r_PCSrcW;
  logic              r_mem_err;

  logic              w_acc, w_done, w_aborted;
  logic [DATA_W-1:0] w_resM;

  assign w_acc = r_ctrlM.memToReg | r_ctrlM.memWrite;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .acc     (w_acc),
    .mem_ack (mem_ack),
    .done    (w_done),
    .aborted (w_aborted)
  );

  assign stall     = !w_done;
  assign mem_req   = w_acc;
  assign mem_we    = r_ctrlM.memWrite;
  assign mem_addr  = r_aluResM[ADDR_W-1:0];
  assign mem_wdata = r_writeDataM;

  assign w_resM = r_ctrlM.memToReg ? (w_aborted ? '0 : mem_rdata) : r_aluResM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrlM      <= '0;
      r_WA3M       <= '0;
      r_aluResM    <= '0;
      r_writeDataM <= '0;
    end else if (!stall) begin
      r_ctrlM      <= '{regWrite: regWriteE, PCSrc: PCSrcE,
                        memToReg: memToRegE, memWrite: memWriteE};
      r_WA3M       <= WA3E;
      r_aluResM    <= aluResE;
      r_writeDataM <= writeDataE;
    end
  end

  // While waiting, W takes a bubble so the instruction retires exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resultW   <= '0;
      r_WA3W      <= '0;
      r_regWriteW <= 1'b0;
      r_PCSrcW    <= 1'b0;
    end else if (w_done) begin
      r_resultW   <= w_resM;
      r_WA3W      <= r_WA3M;
      r_regWriteW <= r_ctrlM.regWrite;
      r_PCSrcW    <= r_ctrlM.PCSrc;
    end else begin
      r_regWriteW <= 1'b0;
      r_PCSrcW    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_mem_err <= 1'b0;
    else if (w_aborted)   r_mem_err <= 1'b1;
    else if (mem_err_clr) r_mem_err <= 1'b0;
  end

  assign resultW   = r_resultW;
  assign WA3W      = r_WA3W;
  assign regWriteW = r_regWriteW;
  assign PCSrcW    = r_PCSrcW;
  assign mem_err   = r_mem_err;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus memory/writeback pipeline register. Sits directly downstream of the datapath execute stage.
- Consumes the execute-stage outputs: ALU result, store data (srcB), destination register, and the regWrite/PCSrc/memToReg/memWrite controls.
- Drives a handshaked data-memory port. Produces resultW, WA3W, regWriteW and PCSrcW, which feed back to the register file write port and the PC mux.
- Stalls upstream while a memory access is outstanding; flags accesses that time out.

Parameters:
- DATA_W, 24: data / result width.
- ADDR_W, 16: memory address width; the address is aluResE[ADDR_W-1:0].
- RA_W, 4: register address width.
- TIMEOUT, 15: maximum wait cycles for mem_ack before the access is aborted (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- regWriteE  in  1  execute-stage register-write enable.
- PCSrcE  in  1  execute-stage PC-source select.
- memToRegE  in  1  execute-stage load select.
- memWriteE  in  1  execute-stage store enable.
- WA3E  in  RA_W  execute-stage destination register.
- aluResE  in  DATA_W  ALU result (address, or the result to write back).
- writeDataE  in  DATA_W  store data (srcB).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data; sampled in the cycle mem_ack is high.
- mem_ack  in  1  access complete, one cycle.
- stall  out  1  hold the upstream stages this cycle (combinational).
- mem_err_clr  in  1  clears mem_err.
- mem_err  out  1  sticky flag: an access timed out.
- resultW  out  DATA_W  writeback data.
- WA3W  out  RA_W  writeback register.
- regWriteW  out  1  writeback enable.
- PCSrcW  out  1  PC-source select for the writeback stage.

Behaviour:
- Reset (async, immediate): all M and W registers clear to 0; FSM goes to READY; the wait counter clears to 0; mem_err clears to 0; mem_req is 0.
  - Reset during an access drops mem_req at once. No completion is recorded.
- M register (EX→M):
  - Loads all E inputs on the clock edge when stall is 0; holds when stall is 1.
  - After reset it holds a bubble (all controls 0).
- Access condition: acc = memToRegM | memWriteM.
  - mem_req = acc & state ∈ {READY, WAIT}.
  - mem_we = memWriteM.
  - mem_addr = aluResM[ADDR_W-1:0].
  - mem_wdata = writeDataM.
  - The request is driven in the first cycle the instruction is in M (zero-wait issue).
- Completion:
  - done = !acc | mem_ack | (state==WAIT & cnt==TIMEOUT).
  - stall = !done.
- FSM transitions:
  - READY, acc & !mem_ack → WAIT, cnt=1.
  - WAIT, !mem_ack & cnt<TIMEOUT → stay in WAIT, cnt+1.
  - WAIT, mem_ack → READY, cnt=0.
  - WAIT, !mem_ack & cnt==TIMEOUT → READY, cnt=0, mem_err←1 (timeout abort).
  - mem_ack in the same cycle as cnt==TIMEOUT: the ack wins, the access completes normally and mem_err is not set.
  - mem_ack while acc=0: ignored.
- W register (M→W), loaded every cycle:
  - If done: resultW = memToRegM ? (aborted ? 0 : mem_rdata) : aluResM. WA3W=WA3M, regWriteW=regWriteM, PCSrcW=PCSrcM.
  - If !done: W loads a bubble (regWriteW=0, PCSrcW=0, resultW/WA3W hold). This prevents a duplicate register write or PC redirect.
- Latency:
  - No-memory instruction: E→W is 2 cycles.
  - Load or store with ack in N cycles after issue: 2+N cycles.
  - Full throughput with zero-wait memory.
- mem_err:
  - Set on a timeout abort; cleared by mem_err_clr.
  - Set and clear in the same cycle: set wins.
  - An aborted store is discarded.
- Widths: no arithmetic beyond the counter, which is $clog2(TIMEOUT+1) bits and never wraps (capped by the transition to READY).

Decomposition:
- Shared package holds:
  - typedef struct packed {regWrite, PCSrc, memToReg, memWrite} ctrl_t;
  - typedef enum {READY, WAIT} mstate_t;
  - default width constants DATA_W=24, ADDR_W=16, RA_W=4.
- One natural sub-module: mem_wait_timer. It holds the FSM and counter; inputs acc, mem_ack; outputs done, aborted.
- The pipeline registers stay in the top level.

Test Plan:
- ALU op: regWriteE=1, aluResE=24'h00_1234, WA3E=3, memory idle → after 2 cycles resultW=24'h001234, WA3W=3, regWriteW=1; stall never high.
- Zero-wait load: memToRegE=1, aluResE=16'h0040, mem_ack=1 in the issue cycle with mem_rdata=24'hABCDEF → mem_req=1, mem_addr=16'h0040, mem_we=0; next cycle resultW=24'hABCDEF, regWriteW=1; no stall.
- 3-wait store: memWriteE=1, writeDataE=24'h00FF00, ack on the 4th request cycle → stall high for 3 cycles; mem_wdata stable at 24'h00FF00; W shows 3 bubbles then one entry with regWriteW=0; upstream held.
- Timeout: load with no ack, TIMEOUT=15 → stall released after 16 request cycles; resultW=0; mem_err=1 until mem_err_clr pulses. Repeat with ack at cnt==15 → completes normally, mem_err stays 0.
- Branch: PCSrcE=1, aluResE=24'h000080 → PCSrcW=1 for exactly one cycle with resultW[15:0]=16'h0080.
- Reset mid-access: assert rst in WAIT with cnt=5 → mem_req, stall, regWriteW, PCSrcW and mem_err all 0 immediately (before the next edge); after release, a new ALU op completes in 2 cycles.
